// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase/state types and widths for the traffic light monitor
package traffic_pkg;
    localparam int TIME_W  = 8;
    localparam int CYCLE_W = 16;

    typedef enum logic [1:0] {PH_RED = 2'd0, PH_GREEN = 2'd1, PH_YELLOW = 2'd2, PH_NONE = 2'd3} phase_e;
    typedef enum logic [1:0] {ST_RED = 2'd0, ST_GREEN = 2'd1, ST_YELLOW = 2'd2, ST_SYNC = 2'd3} state_e;

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        return p == PH_RED ? PH_GREEN : p == PH_GREEN ? PH_YELLOW : p == PH_YELLOW ? PH_RED : PH_NONE;
    endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating phase-length counter with clear, restart-at-one and increment
module phase_timer
    import traffic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              start,
    input  logic              inc,
    output logic [TIME_W-1:0] count
);
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (start)
            count <= TIME_W'(1);
        else if (inc && count != '1)
            count <= count + 1'b1;
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks lamp legality, phase order and phase durations of a traffic light controller
module traffic_light_monitor
    import traffic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               maint_mode,
    input  logic               err_clr,
    input  logic               red_light,
    input  logic               yellow_light,
    input  logic               green_light,
    input  logic [TIME_W-1:0]  red_time,
    input  logic [TIME_W-1:0]  yellow_time,
    input  logic [TIME_W-1:0]  green_time,
    output logic [1:0]         cur_phase,
    output logic               len_valid,
    output logic [1:0]         len_phase,
    output logic [TIME_W-1:0]  measured_len,
    output logic               err_illegal,
    output logic               err_sequence,
    output logic               err_duration,
    output logic [CYCLE_W-1:0] cycle_count
);
    state_e            state;
    logic [1:0]        prev, smp, n_full;
    logic [TIME_W-1:0] cnt, lat, prog_time;
    logic              legal, change, trk, first;

    assign legal     = $onehot({red_light, yellow_light, green_light});
    assign smp       = !legal ? PH_NONE : red_light ? PH_RED : green_light ? PH_GREEN : PH_YELLOW;
    assign change    = legal && smp != prev;
    assign trk       = state != ST_SYNC;
    assign prog_time = smp == PH_RED ? red_time : smp == PH_GREEN ? green_time : yellow_time;

    phase_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (maint_mode || !legal),
        .start (change),
        .inc   (1'b1),
        .count (cnt)
    );

    // first marks the partial phase entered from SYNC; n_full counts fully tracked phases since then
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_SYNC;
            cur_phase    <= PH_NONE;
            prev         <= PH_NONE;
            len_valid    <= 1'b0;
            len_phase    <= '0;
            measured_len <= '0;
            err_illegal  <= 1'b0;
            err_sequence <= 1'b0;
            err_duration <= 1'b0;
            cycle_count  <= '0;
            lat          <= '0;
            first        <= 1'b1;
            n_full       <= '0;
        end else begin
            prev         <= smp;
            len_valid    <= 1'b0;
            err_illegal  <= err_illegal & ~err_clr;
            err_sequence <= err_sequence & ~err_clr;
            err_duration <= err_duration & ~err_clr;
            if (maint_mode || !legal) begin
                state     <= ST_SYNC;
                cur_phase <= PH_NONE;
                if (!maint_mode)
                    err_illegal <= 1'b1;
            end else if (change) begin
                state     <= state_e'(smp);
                cur_phase <= smp;
                lat       <= prog_time;
                if (trk && !first) begin
                    len_valid    <= 1'b1;
                    len_phase    <= cur_phase;
                    measured_len <= cnt;
                    if (cnt != lat)
                        err_duration <= 1'b1;
                end
                if (trk && smp == next_phase(cur_phase)) begin
                    first  <= 1'b0;
                    n_full <= first ? 2'd0 : n_full == 2'd3 ? 2'd3 : n_full + 2'd1;
                    if (!first && cur_phase == PH_YELLOW && n_full >= 2'd2 && cycle_count != '1)
                        cycle_count <= cycle_count + 1'b1;
                end else begin
                    if (trk)
                        err_sequence <= 1'b1;
                    first  <= 1'b1;
                    n_full <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed lamp sequences with a len_valid scoreboard and flag checks
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, RG = 3'b101, OFF = 3'b000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         maint_mode = 1'b0, err_clr = 1'b0;
    logic         red_light = 1'b0, yellow_light = 1'b0, green_light = 1'b0;
    logic [7:0]   red_time = 8'd5, yellow_time = 8'd2, green_time = 8'd3;
    logic [1:0]   cur_phase, len_phase;
    logic         len_valid, err_illegal, err_sequence, err_duration;
    logic [7:0]   measured_len;
    logic [15:0]  cycle_count;

    int           nvec = 0, nerr = 0;
    logic [9:0]   exp_q[$];
    logic [9:0]   exp_head;

    traffic_light_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .maint_mode   (maint_mode),
        .err_clr      (err_clr),
        .red_light    (red_light),
        .yellow_light (yellow_light),
        .green_light  (green_light),
        .red_time     (red_time),
        .yellow_time  (yellow_time),
        .green_time   (green_time),
        .cur_phase    (cur_phase),
        .len_valid    (len_valid),
        .len_phase    (len_phase),
        .measured_len (measured_len),
        .err_illegal  (err_illegal),
        .err_sequence (err_sequence),
        .err_duration (err_duration),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cur_phase"}, 16'(cur_phase), 16'd3);
        chk({tag, "_len_valid"}, 16'(len_valid), 16'd0);
        chk({tag, "_len_phase"}, 16'(len_phase), 16'd0);
        chk({tag, "_measured_len"}, 16'(measured_len), 16'd0);
        chk({tag, "_err_illegal"}, 16'(err_illegal), 16'd0);
        chk({tag, "_err_sequence"}, 16'(err_sequence), 16'd0);
        chk({tag, "_err_duration"}, 16'(err_duration), 16'd0);
        chk({tag, "_cycle_count"}, cycle_count, 16'd0);
    endtask

    task automatic push(input logic [1:0] p, input int n);
        exp_q.push_back({p, 8'(n)});
    endtask

    task automatic lamps(input logic [2:0] v, input int n);
        {red_light, yellow_light, green_light} = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic lamps_clr(input logic [2:0] v, input int n);
        err_clr = 1'b1;
        lamps(v, 1);
        err_clr = 1'b0;
        lamps(v, n - 1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (len_valid) begin
                    nvec++;
                    if (exp_q.size() == 0) begin
                        nerr++;
                        $display("FAIL unexpected_len: got phase=%0d len=%0d, expected no len_valid", len_phase, measured_len);
                    end else begin
                        exp_head = exp_q.pop_front();
                        if ({len_phase, measured_len} !== exp_head) begin
                            nerr++;
                            $display("FAIL len_record: got phase=%0d len=%0d expected phase=%0d len=%0d",
                                     len_phase, measured_len, exp_head[9:8], exp_head[7:0]);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        // controller-faithful cycles; first RED is the unchecked partial phase
        lamps(R, 5);
        chk("cur_phase_red", 16'(cur_phase), 16'd0);
        lamps(G, 3);
        push(PH_GREEN, 3);  lamps(Y, 2);
        push(PH_YELLOW, 2); lamps(R, 5);
        push(PH_RED, 5);    lamps(G, 3);
        push(PH_GREEN, 3);  lamps(Y, 2);
        push(PH_YELLOW, 2); lamps(R, 5);
        push(PH_RED, 5);    lamps(G, 3);
        push(PH_GREEN, 3);  lamps(Y, 2);
        push(PH_YELLOW, 2); lamps(R, 5);
        chk("cycles_after_nominal", cycle_count, 16'd2);
        chk("no_err_nominal", 16'({err_illegal, err_sequence, err_duration}), 16'd0);

        // long GREEN
        push(PH_RED, 5);    lamps(G, 4);
        push(PH_GREEN, 4);  lamps(Y, 2);
        chk("err_duration_long_green", 16'(err_duration), 16'd1);
        push(PH_YELLOW, 2); lamps_clr(R, 5);
        chk("err_duration_cleared", 16'(err_duration), 16'd0);
        chk("cycles_after_long_green", cycle_count, 16'd3);

        // illegal lamp vector
        lamps(RG, 1);
        chk("err_illegal_set", 16'(err_illegal), 16'd1);
        chk("cur_phase_none_illegal", 16'(cur_phase), 16'd3);
        lamps(G, 3);
        chk("cur_phase_resync_green", 16'(cur_phase), 16'd1);
        lamps(Y, 2);
        push(PH_YELLOW, 2); lamps_clr(R, 5);
        chk("err_illegal_cleared", 16'(err_illegal), 16'd0);
        chk("no_duration_after_resync", 16'(err_duration), 16'd0);

        // maintenance
        maint_mode = 1'b1;
        lamps(Y, 2);
        lamps(G, 2);
        lamps(OFF, 2);
        chk("maint_cur_phase", 16'(cur_phase), 16'd3);
        chk("maint_no_err", 16'({err_illegal, err_sequence, err_duration}), 16'd0);
        chk("maint_cycles_frozen", cycle_count, 16'd3);
        maint_mode = 1'b0;
        lamps(R, 7);
        lamps(G, 3);
        chk("post_maint_unchecked", 16'(err_duration), 16'd0);
        push(PH_GREEN, 3);  lamps(Y, 2);

        // mid-RED reconfiguration
        push(PH_YELLOW, 2); lamps(R, 2);
        red_time = 8'd10;
        lamps(R, 3);
        push(PH_RED, 5);    lamps(G, 3);
        chk("old_red_time_used", 16'(err_duration), 16'd0);
        push(PH_GREEN, 3);  lamps(Y, 2);
        push(PH_YELLOW, 2); lamps(R, 10);
        push(PH_RED, 10);   lamps(G, 3);
        chk("new_red_time_used", 16'(err_duration), 16'd0);
        push(PH_GREEN, 3);  lamps(Y, 2);
        push(PH_YELLOW, 2); lamps(R, 10);
        chk("cycles_after_reconfig", cycle_count, 16'd5);

        // RED->YELLOW with a coincident clear: set wins
        push(PH_RED, 10);   lamps_clr(Y, 2);
        chk("err_sequence_set_wins", 16'(err_sequence), 16'd1);
        chk("cur_phase_yellow", 16'(cur_phase), 16'd2);
        lamps_clr(R, 10);
        chk("err_sequence_cleared", 16'(err_sequence), 16'd0);

        // zero programmed time never matches
        green_time = 8'd0;
        push(PH_RED, 10);   lamps(G, 3);
        push(PH_GREEN, 3);  lamps(Y, 2);
        chk("zero_time_mismatch", 16'(err_duration), 16'd1);
        green_time = 8'd3;
        red_time   = 8'd5;
        push(PH_YELLOW, 2); lamps_clr(R, 5);
        chk("cycles_before_reset", cycle_count, 16'd6);
        chk("err_duration_cleared2", 16'(err_duration), 16'd0);

        // asynchronous reset mid-GREEN
        push(PH_RED, 5);    lamps(G, 2);
        #2 rst = 1'b0;
        #1 chk_reset("async_reset");
        @(negedge clk);
        rst = 1'b1;
        lamps(G, 3);
        lamps(Y, 2);
        push(PH_YELLOW, 2); lamps(R, 5);
        chk("post_reset_no_duration", 16'(err_duration), 16'd0);
        chk("post_reset_cycles", cycle_count, 16'd0);
        chk("post_reset_cur_phase", 16'(cur_phase), 16'd0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have one clock and reset: asynchronous, active-low.
REQ-002 clk  in  1  system clock; all sampling on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 maint_mode  in  1  controller maintenance active; checking suspended.
REQ-005 err_clr  in  1  single-cycle pulse; clears all sticky error flags.
REQ-006 red_light, yellow_light, green_light  in  1 each  observed lamp outputs of the traffic light controller.
REQ-007 red_time, yellow_time, green_time  in  8 each  programmed phase durations, in clk cycles.
REQ-008 cur_phase  out  2  decoded current phase: RED=0, GREEN=1, YELLOW=2, NONE=3.
REQ-009 len_valid  out  1  one-cycle pulse; a completed phase was measured.
REQ-010 len_phase  out  2  phase that just ended; valid with len_valid.
REQ-011 measured_len  out  8  duration of the ended phase, in cycles; saturates at 255.
REQ-012 err_illegal, err_sequence, err_duration  out  1 each  sticky error flags.
REQ-013 cycle_count  out  16  count of complete RED->GREEN->YELLOW->RED cycles; saturates at 65535.

Function
REQ-014 SHALL sample the three lamps every cycle; legal vectors are exactly one-hot.
REQ-015 FSM states SHALL be SYNC, RED, GREEN, YELLOW.
- SYNC: await a legal phase change.
- A phase change is a sampled legal vector differing from the previous sample.
REQ-016 Tracking, on a phase change: only RED->GREEN, GREEN->YELLOW and YELLOW->RED are legal.
- Any other change sets err_sequence.
- The FSM re-enters tracking at the new phase, which is treated as a first phase.
REQ-017 A non-one-hot sample outside maint_mode SHALL set err_illegal, force SYNC and set cur_phase=NONE.
REQ-018 Phase counter: 1 on the first sampled cycle of a phase; +1 per cycle; saturates at 255.
REQ-019 On the edge sampling a phase change, SHALL register:
- len_valid=1 for exactly one cycle;
- len_phase = ended phase;
- measured_len = ended phase's count.
REQ-020 Programmed time for a phase SHALL be latched at that phase's first cycle.
- Mid-phase reconfiguration affects only the next phase.
REQ-021 err_duration SHALL set when measured_len differs from the latched time.
- No check, and no len_valid, for the first (partial) phase after SYNC.
REQ-022 cycle_count SHALL increment on each YELLOW->RED transition that completes a fully tracked RED, GREEN, YELLOW sequence.
REQ-023 maint_mode=1 SHALL, from the next cycle:
- force SYNC and cur_phase=NONE;
- suppress all error setting and len_valid;
- freeze cycle_count.
REQ-024 After maint_mode falls, the first legal phase change SHALL resume tracking.
REQ-025 err_clr coinciding with a new error SHALL leave that flag set (set wins).
REQ-026 Programmed time 0 SHALL never match; any measured phase against it sets err_duration.

Reset
REQ-027 rst low SHALL immediately force:
- SYNC, cur_phase=NONE;
- len_valid=0, len_phase=0, measured_len=0;
- all errors=0, cycle_count=0, counters=0.
REQ-028 Reset mid-phase SHALL discard the partial measurement; the first post-reset phase is unchecked.

Structure
REQ-029 Shared package traffic_pkg SHALL hold:
- phase enum (PH_RED, PH_GREEN, PH_YELLOW, PH_NONE);
- monitor state enum;
- TIME_W=8, CYCLE_W=16.
REQ-030 One sub-module, phase_timer, SHALL implement the saturating clear/increment counter.

Verification
REQ-031 Times 5/2/3 red/yellow/green, controller-faithful lamps:
- len_valid pulses with lengths RED=5, GREEN=3, YELLOW=2;
- no errors; cycle_count increments each full cycle.
REQ-032 GREEN held 4 cycles with green_time=3 -> err_duration=1 after GREEN ends, measured_len=4; err_clr -> 0.
REQ-033 red_light and green_light both high for 1 cycle -> err_illegal=1, cur_phase=NONE, SYNC; next legal change resumes without err_duration.
REQ-034 maint_mode=1 with lamp sequence yellow, green, all off:
- no errors, no len_valid, cycle_count frozen;
- after exit, first change produces no duration check.
REQ-035 Sequence violation and reconfiguration:
- RED->YELLOW -> err_sequence=1.
- red_time 5->10 mid-RED -> current RED checked against 5, next RED against 10.
REQ-036 rst asserted mid-GREEN -> all outputs at reset values immediately; the first post-reset phase is unchecked.
